// File: rtl/cpu7_byp_pkg.sv
// Shared types for the cpu7 execute bypass unit: stage record layout,
// forward-source codes and register/counter constants.
package cpu7_byp_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_src_e;

    // Writer identity common to every stage; data words are GRLEN wide
    // and live next to the records in the top so GRLEN stays a parameter.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wen;
    } wr_t;

    typedef struct packed {
        wr_t  wr;
        logic load;
    } e_rec_t;

    // done marks a load whose data was captured while M was frozen.
    typedef struct packed {
        wr_t  wr;
        logic load;
        logic done;
    } m_rec_t;

    localparam wr_t WR_BUBBLE = '0;

    function automatic logic wr_hits(input wr_t wr, input logic [REG_W-1:0] rs);
        return wr.valid && wr.wen && (wr.rd == rs) && (rs != REG_ZERO);
    endfunction

endpackage

// File: rtl/cpu7_byp_port.sv
// One decode read port of the bypass unit: picks the youngest in-flight
// writer of rs, falling back to the raw register-file read.
module cpu7_byp_port
    import cpu7_byp_pkg::*;
#(
    parameter int GRLEN = 32
) (
    input  logic [REG_W-1:0] rs,
    input  logic [GRLEN-1:0] rf_rdata,
    input  wr_t              e_wr,
    input  logic [GRLEN-1:0] alu_res_e,
    input  wr_t              m_wr,
    input  logic             m_pend,
    input  logic [GRLEN-1:0] m_data,
    input  logic [GRLEN-1:0] lsu_rdata_m,
    input  wr_t              w_wr,
    input  logic [GRLEN-1:0] w_data,
    output logic [GRLEN-1:0] rdata,
    output fwd_src_e         src
);

    // An E-stage load also selects FWD_E; the top turns that into a
    // load-use stall, so the value returned for it never gets consumed.
    always_comb begin
        src   = FWD_RF;
        rdata = rf_rdata;
        if (rs == REG_ZERO) begin
            rdata = '0;
        end else if (wr_hits(e_wr, rs)) begin
            src   = FWD_E;
            rdata = alu_res_e;
        end else if (wr_hits(m_wr, rs)) begin
            src   = FWD_M;
            rdata = m_pend ? lsu_rdata_m : m_data;
        end else if (wr_hits(w_wr, rs)) begin
            src   = FWD_W;
            rdata = w_data;
        end
    end

endmodule

// File: rtl/cpu7_exu_byp.sv
// cpu7 execute bypass/interlock unit: tracks E/M/W writers, forwards operands,
// raises load-use and memory-wait stalls, and drives the reg_file write port.
// Optional performance counters are built when BYP_PERF_CNT_EN is defined.
module cpu7_exu_byp
    import cpu7_byp_pkg::*;
#(
    parameter int GRLEN  = 32,
    parameter int RPORTS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_in,
    input  logic                    d_valid,
    input  logic [REG_W-1:0]        d_rd,
    input  logic                    d_wen,
    input  logic                    d_load,
    input  logic [RPORTS*REG_W-1:0] d_rs,
    input  logic [RPORTS*GRLEN-1:0] rf_rdata_d,
    output logic [RPORTS*GRLEN-1:0] byp_rdata_d,
    output logic                    byp_stall_d,
    input  logic [GRLEN-1:0]        alu_res_e,
    input  logic                    lsu_rdata_valid_m,
    input  logic [GRLEN-1:0]        lsu_rdata_m,
    output logic                    irf_wen_w,
    output logic [REG_W-1:0]        irf_rd_w,
    output logic [GRLEN-1:0]        irf_wdata_w,
    output logic [CNT_W-1:0]        perf_fwd_cnt,
    output logic [CNT_W-1:0]        perf_stall_cnt
);

    e_rec_t           e_q;
    m_rec_t           m_q;
    wr_t              w_q;
    logic [GRLEN-1:0] m_data_q;
    logic [GRLEN-1:0] w_data_q;

    fwd_src_e          src [RPORTS];
    logic [RPORTS-1:0] load_use;
    logic              m_pend;
    logic              mwait;
    logic              freeze;
    logic              issue;

    assign m_pend = m_q.wr.valid & m_q.load & ~m_q.done;
    assign mwait  = m_pend & ~lsu_rdata_valid_m;
    assign freeze = stall_in | mwait;

    for (genvar i = 0; i < RPORTS; i++) begin : g_port
        cpu7_byp_port #(
            .GRLEN(GRLEN)
        ) u_port (
            .rs          (d_rs[i*REG_W +: REG_W]),
            .rf_rdata    (rf_rdata_d[i*GRLEN +: GRLEN]),
            .e_wr        (e_q.wr),
            .alu_res_e   (alu_res_e),
            .m_wr        (m_q.wr),
            .m_pend      (m_pend),
            .m_data      (m_data_q),
            .lsu_rdata_m (lsu_rdata_m),
            .w_wr        (w_q),
            .w_data      (w_data_q),
            .rdata       (byp_rdata_d[i*GRLEN +: GRLEN]),
            .src         (src[i])
        );

        assign load_use[i] = (src[i] == FWD_E) & e_q.load;
    end

    assign byp_stall_d = d_valid & (freeze | (|load_use));
    assign issue       = d_valid & ~byp_stall_d;

    // Bubbles carry zero data so the write port stays quiet until real work retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= WR_BUBBLE;
            m_data_q <= '0;
            w_data_q <= '0;
        end else if (freeze) begin
            w_q      <= WR_BUBBLE;
            w_data_q <= '0;
            // Only reachable under stall_in: keep the returning load data in M.
            if (m_pend && lsu_rdata_valid_m) begin
                m_q.done <= 1'b1;
                m_data_q <= lsu_rdata_m;
            end
        end else begin
            if (issue) begin
                e_q.wr.valid <= 1'b1;
                e_q.wr.rd    <= d_rd;
                e_q.wr.wen   <= d_wen;
                e_q.load     <= d_load;
            end else begin
                e_q <= '0;
            end
            m_q.wr   <= e_q.wr;
            m_q.load <= e_q.load;
            m_q.done <= 1'b0;
            m_data_q <= e_q.wr.valid ? alu_res_e : '0;
            w_q      <= m_q.wr;
            if (!m_q.wr.valid) begin
                w_data_q <= '0;
            end else begin
                w_data_q <= m_pend ? lsu_rdata_m : m_data_q;
            end
        end
    end

    assign irf_wen_w   = w_q.valid & w_q.wen & (w_q.rd != REG_ZERO);
    assign irf_rd_w    = w_q.rd;
    assign irf_wdata_w = w_data_q;

`ifdef BYP_PERF_CNT_EN
    logic             fwd_evt;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        fwd_evt = 1'b0;
        for (int i = 0; i < RPORTS; i++) begin
            if (d_valid && (src[i] != FWD_RF)) begin
                fwd_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fwd_evt && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
            if (byp_stall_d && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_fwd_cnt   = fwd_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fwd_cnt   = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu7_exu_byp.sv
// Self-checking bench for cpu7_exu_byp: random instruction stream checked against
// a program-order register model plus a stage-occupancy timing model.
module tb_cpu7_exu_byp;

    localparam int GRLEN  = 32;
    localparam int RPORTS = 2;
    localparam int NREG   = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    stall_in;
    logic                    d_valid;
    logic [4:0]              d_rd;
    logic                    d_wen;
    logic                    d_load;
    logic [RPORTS*5-1:0]     d_rs;
    logic [RPORTS*GRLEN-1:0] rf_rdata_d;
    logic [RPORTS*GRLEN-1:0] byp_rdata_d;
    logic                    byp_stall_d;
    logic [GRLEN-1:0]        alu_res_e;
    logic                    lsu_rdata_valid_m;
    logic [GRLEN-1:0]        lsu_rdata_m;
    logic                    irf_wen_w;
    logic [4:0]              irf_rd_w;
    logic [GRLEN-1:0]        irf_wdata_w;
    logic [31:0]             perf_fwd_cnt;
    logic [31:0]             perf_stall_cnt;

    always #5 clk = ~clk;

    cpu7_exu_byp #(.GRLEN(GRLEN), .RPORTS(RPORTS)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .d_valid          (d_valid),
        .d_rd             (d_rd),
        .d_wen            (d_wen),
        .d_load           (d_load),
        .d_rs             (d_rs),
        .rf_rdata_d       (rf_rdata_d),
        .byp_rdata_d      (byp_rdata_d),
        .byp_stall_d      (byp_stall_d),
        .alu_res_e        (alu_res_e),
        .lsu_rdata_valid_m(lsu_rdata_valid_m),
        .lsu_rdata_m      (lsu_rdata_m),
        .irf_wen_w        (irf_wen_w),
        .irf_rd_w         (irf_rd_w),
        .irf_wdata_w      (irf_wdata_w),
        .perf_fwd_cnt     (perf_fwd_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    // stage: 1 = E, 2 = M, 3 = W
    typedef struct {
        logic [4:0]          rd;
        bit                  wen;
        bit                  load;
        logic [RPORTS*5-1:0] rs;
        logic [31:0]         res;
        int                  stage;
        bit                  done;
    } ins_t;

    ins_t        pipe[$];
    ins_t        prog[$];
    ins_t        cur;
    bit          have_cur;
    logic [31:0] rf   [32];
    logic [31:0] arch [32];
    int          ntests;
    int          nfail;
    int          stall_pct;
    int          lsu_pct;
    int          dv_pct;
    logic [31:0] exp_fwd_cnt;
    logic [31:0] exp_stall_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int at_stage(input int s);
        for (int k = 0; k < pipe.size(); k++) begin
            if (pipe[k].stage == s) return k;
        end
        return -1;
    endfunction

    function automatic ins_t rand_ins();
        ins_t t;
        t.rd    = 5'($urandom_range(0, NREG-1));
        t.wen   = ($urandom_range(0, 9) < 8);
        t.load  = ($urandom_range(0, 9) < 3);
        for (int p = 0; p < RPORTS; p++) t.rs[p*5 +: 5] = 5'($urandom_range(0, NREG-1));
        t.res   = $urandom;
        t.stage = 0;
        t.done  = 0;
        return t;
    endfunction

    function automatic ins_t mk(input logic [4:0] rd, input bit load, input logic [4:0] rs0,
                                input logic [4:0] rs1, input logic [31:0] res);
        ins_t t;
        t.rd    = rd;
        t.wen   = 1'b1;
        t.load  = load;
        t.rs    = {rs1, rs0};
        t.res   = res;
        t.stage = 0;
        t.done  = 0;
        return t;
    endfunction

    task automatic cycle(input bit allow_lsu);
        int         ie, im, iw;
        bit         lsu_v, mw, frz, luse, exp_stall, iss, fwd_evt;
        logic [4:0] rs;
        ie = at_stage(1);
        im = at_stage(2);
        iw = at_stage(3);
        if (!have_cur && prog.size() > 0) begin
            cur = prog.pop_front();
            have_cur = 1;
        end else if (!have_cur && $urandom_range(0, 99) < dv_pct) begin
            cur = rand_ins();
            have_cur = 1;
        end
        d_valid = have_cur;
        if (have_cur) begin
            d_rd = cur.rd; d_wen = cur.wen; d_load = cur.load; d_rs = cur.rs;
        end else begin
            d_rd = 5'($urandom); d_wen = 1'($urandom); d_load = 1'($urandom);
            d_rs = RPORTS*5'($urandom);
        end
        for (int p = 0; p < RPORTS; p++) begin
            rs = d_rs[p*5 +: 5];
            rf_rdata_d[p*GRLEN +: GRLEN] = (rs == 0) ? $urandom : rf[rs];
        end
        stall_in  = ($urandom_range(0, 99) < stall_pct);
        alu_res_e = (ie >= 0 && !pipe[ie].load) ? pipe[ie].res : $urandom;
        if (im >= 0 && pipe[im].load && !pipe[im].done) begin
            lsu_v       = allow_lsu && ($urandom_range(0, 99) < lsu_pct);
            lsu_rdata_m = lsu_v ? pipe[im].res : $urandom;
        end else begin
            lsu_v       = ($urandom_range(0, 99) < 15);
            lsu_rdata_m = $urandom;
        end
        lsu_rdata_valid_m = lsu_v;
        #2;
        mw  = (im >= 0) && pipe[im].load && !pipe[im].done && !lsu_v;
        frz = stall_in || mw;
        luse = 0;
        fwd_evt = 0;
        for (int p = 0; p < RPORTS; p++) begin
            rs = d_rs[p*5 +: 5];
            if (rs != 0 && ie >= 0 && pipe[ie].load && pipe[ie].wen && pipe[ie].rd == rs) luse = 1;
            for (int k = 0; k < pipe.size(); k++) begin
                if (d_valid && rs != 0 && pipe[k].wen && pipe[k].rd == rs) fwd_evt = 1;
            end
        end
        exp_stall = d_valid && (frz || luse);
        iss = d_valid && !exp_stall;
        check("stall", byp_stall_d, exp_stall);
        if (iss) begin
            for (int p = 0; p < RPORTS; p++) begin
                rs = d_rs[p*5 +: 5];
                check($sformatf("operand%0d_r%0d", p, rs), byp_rdata_d[p*GRLEN +: GRLEN],
                      (rs == 0) ? 32'h0 : arch[rs]);
            end
        end
        if (iw >= 0 && pipe[iw].wen && pipe[iw].rd != 0) begin
            check("irf_wen", irf_wen_w, 1);
            check("irf_rd", irf_rd_w, pipe[iw].rd);
            check("irf_wdata", irf_wdata_w, pipe[iw].res);
        end else begin
            check("irf_wen_idle", irf_wen_w, 0);
        end
`ifdef BYP_PERF_CNT_EN
        check("perf_fwd", perf_fwd_cnt, exp_fwd_cnt);
        check("perf_stall", perf_stall_cnt, exp_stall_cnt);
`else
        check("perf_fwd_off", perf_fwd_cnt, 0);
        check("perf_stall_off", perf_stall_cnt, 0);
`endif
        @(posedge clk);
        if (fwd_evt) exp_fwd_cnt++;
        if (exp_stall) exp_stall_cnt++;
        if (iw >= 0) begin
            if (pipe[iw].wen && pipe[iw].rd != 0) rf[pipe[iw].rd] = pipe[iw].res;
            pipe.delete(iw);
        end
        if (frz) begin
            im = at_stage(2);
            if (im >= 0 && pipe[im].load && lsu_v) pipe[im].done = 1;
        end else begin
            for (int k = 0; k < pipe.size(); k++) pipe[k].stage++;
            if (iss) begin
                cur.stage = 1;
                cur.done  = 0;
                pipe.push_back(cur);
                if (cur.wen && cur.rd != 0) arch[cur.rd] = cur.res;
                have_cur = 0;
            end
        end
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, byp_stall_d, 0);
        check({tag, "_irf_wen"}, irf_wen_w, 0);
        check({tag, "_irf_rd"}, irf_rd_w, 0);
        check({tag, "_irf_wdata"}, irf_wdata_w, 0);
        check({tag, "_perf_fwd"}, perf_fwd_cnt, 0);
        check({tag, "_perf_stall"}, perf_stall_cnt, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int im;
        ntests = 0; nfail = 0;
        stall_pct = 0; lsu_pct = 40; dv_pct = 80;
        have_cur = 0;
        exp_fwd_cnt = 0; exp_stall_cnt = 0;
        for (int k = 0; k < 32; k++) rf[k] = (k == 0) ? 32'h0 : $urandom;
        arch = rf;

        reset = 1; stall_in = 0; d_valid = 0; d_rd = 0; d_wen = 0; d_load = 0; d_rs = '0;
        rf_rdata_d = '0; alu_res_e = $urandom; lsu_rdata_valid_m = 0; lsu_rdata_m = $urandom;
        #2;
        check_quiet("in_reset");
        check("in_reset_rdata", byp_rdata_d[31:0], 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        #2;
        check_quiet("post_reset");
        @(posedge clk); #1;

        // ADDI r1; ADD r2,r1,r1; LD r3; use r3; writer to r0 reading r0
        prog.push_back(mk(5'd1, 0, 5'd0, 5'd0, 32'h10));
        prog.push_back(mk(5'd2, 0, 5'd1, 5'd1, 32'h20));
        prog.push_back(mk(5'd3, 1, 5'd0, 5'd0, 32'hDEAD));
        prog.push_back(mk(5'd4, 0, 5'd3, 5'd3, 32'h1234));
        prog.push_back(mk(5'd0, 0, 5'd0, 5'd0, 32'h55));
        for (int k = 0; k < 20; k++) cycle(1);

        stall_pct = 10;
        for (int k = 0; k < 1500; k++) cycle(1);
        stall_pct = 40; lsu_pct = 25;
        for (int k = 0; k < 400; k++) cycle(1);

        // reset while a load waits in M, followed by a stray data return
        stall_pct = 5;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            cycle(0);
            im = at_stage(2);
            found = (im >= 0) && pipe[im].load && !pipe[im].done;
        end
        ntests++;
        assert (found) else begin
            nfail++;
            $error("FAIL load_wait_setup: observed %0d expected %0d", found, 1);
        end
        reset = 1; d_valid = 0; stall_in = 0; lsu_rdata_valid_m = 0;
        #2;
        check_quiet("mid_load_reset");
        @(posedge clk); #1;
        lsu_rdata_valid_m = 1; lsu_rdata_m = $urandom;
        @(posedge clk); #1;
        reset = 0;
        pipe.delete();
        arch = rf;
        have_cur = 0;
        exp_fwd_cnt = 0; exp_stall_cnt = 0;
        #2;
        check_quiet("stray_lsu");
        @(posedge clk); #1;
        lsu_rdata_valid_m = 0;
        #2;
        check_quiet("after_stray");
        @(posedge clk); #1;

        stall_pct = 10; lsu_pct = 40;
        for (int k = 0; k < 300; k++) cycle(1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
